// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - start/result handshake bundle for the M-extension execute unit
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            Start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            Kill;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;

  modport master (
    output Start, Funct3, SrcA, SrcB, Kill,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, Funct3, SrcA, SrcB, Kill,
    output Busy, Done, Result
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - sequential RV M-extension unit: shift-add multiply, restoring divide
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic              neg;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Result = result_q;

  logic            a_signed, b_signed, a_neg, b_neg, start_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_signed    = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
                  (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
    b_signed    = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
    a_neg       = a_signed & bus.SrcA[XLEN-1];
    b_neg       = b_signed & bus.SrcB[XLEN-1];
    a_mag       = a_neg ? -bus.SrcA : bus.SrcA;
    b_mag       = b_neg ? -bus.SrcB : bus.SrcB;
    // REM follows the dividend only; every other op negates on differing signs
    start_neg   = (bus.Funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
    div_zero    = bus.Funct3[2] && (bus.SrcB == '0);
    div_ovf     = bus.Funct3[2] && !bus.Funct3[0] && (bus.SrcA == MIN) && (bus.SrcB == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = bus.Funct3[1] ? bus.SrcA : '1;
    else if (div_ovf)
      special_res = bus.Funct3[1] ? '0 : MIN;
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] step_acc;

  // acc holds {high, multiplier} when multiplying, {remainder, dividend/quotient} when dividing
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd};
    step_acc  = {mul_sum, acc[XLEN-1:1]};
    if (op[2]) begin
      if (!div_diff[XLEN])
        step_acc = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        step_acc = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  logic [2*XLEN-1:0] fin_prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    fin_prod = neg ? -step_acc : step_acc;
    quo      = step_acc[XLEN-1:0];
    rem      = step_acc[2*XLEN-1:XLEN];
    case (op)
      3'b000:         final_res = fin_prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         final_res = fin_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: final_res = neg ? -quo : quo;
      default:        final_res = neg ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      op       <= '0;
      neg      <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.Kill) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          acc   <= step_acc;
          count <= count + CW'(1);
          if (count == CW'(XLEN - 1)) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= final_res;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.Start) begin
            op    <= bus.Funct3;
            neg   <= start_neg;
            count <= '0;
            if (special) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= special_res;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
              opnd   <= bus.Funct3[2] ? b_mag : a_mag;
              acc    <= bus.Funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit at XLEN=32 and XLEN=8
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) b32 ();
  muldiv_unit_if #(.XLEN(8))  b8 ();

  muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  muldiv_unit #(.XLEN(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

  int checks = 0;
  int errors = 0;
  logic [31:0] q32[$];
  logic [7:0]  q8[$];
  int done32 = 0;
  int done8 = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input int xl, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [127:0] ua, ub, sa, sb, r;
    logic [31:0] mask;
    mask = (xl == 32) ? 32'hFFFF_FFFF : ((32'd1 << xl) - 32'd1);
    ua = {96'b0, a & mask};
    ub = {96'b0, b & mask};
    sa = a[xl-1] ? ua - (128'sd1 <<< xl) : ua;
    sb = b[xl-1] ? ub - (128'sd1 <<< xl) : ub;
    case (f3)
      3'd0:    r = sa * sb;
      3'd1:    r = (sa * sb) >>> xl;
      3'd2:    r = (sa * ub) >>> xl;
      3'd3:    r = (ua * ub) >>> xl;
      3'd4:    r = (ub == 0) ? 128'sd0 - 1 : sa / sb;
      3'd5:    r = (ub == 0) ? 128'sd0 - 1 : ua / ub;
      3'd6:    r = (ub == 0) ? ua : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return r[31:0] & mask;
  endfunction

  always @(negedge clk) begin
    if (b32.Done === 1'b1) begin
      done32++;
      check_eq("done32_pending", q32.size() != 0, 1);
      if (q32.size() != 0) check_eq("result32", b32.Result, q32.pop_front());
    end
    if (b8.Done === 1'b1) begin
      done8++;
      check_eq("done8_pending", q8.size() != 0, 1);
      if (q8.size() != 0) check_eq("result8", b8.Result, q8.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done32(input int k0, output int k);
    k = k0;
    while (k <= 60 && b32.Done !== 1'b1) begin
      step();
      k++;
    end
    if (k > 60) k = -1;
  endtask

  task automatic run32(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int lat, k;
    bit busy_ok, seen;
    lat = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
    q32.push_back(exp);
    b32.Start = 1'b1; b32.Funct3 = f3; b32.SrcA = a; b32.SrcB = b;
    step();
    b32.Start = 1'b0;
    k = 1; busy_ok = 1'b1; seen = 1'b0;
    while (k <= 40 && !seen) begin
      if (b32.Done === 1'b1) seen = 1'b1;
      if (b32.Busy !== (k < lat)) busy_ok = 1'b0;
      if (!seen) begin step(); k++; end
    end
    check_eq({tag, "_lat"}, seen ? k : 0, lat);
    check_eq({tag, "_busy"}, busy_ok, 1);
  endtask

  task automatic run8(input logic [2:0] f3, input logic [7:0] a, input logic [7:0] b);
    int lat, k;
    bit busy_ok, seen;
    lat = (f3[2] && (b == 0 || (!f3[0] && a == 8'h80 && b == 8'hFF))) ? 1 : 9;
    q8.push_back(model(8, f3, {24'b0, a}, {24'b0, b}));
    b8.Start = 1'b1; b8.Funct3 = f3; b8.SrcA = a; b8.SrcB = b;
    step();
    b8.Start = 1'b0;
    k = 1; busy_ok = 1'b1; seen = 1'b0;
    while (k <= 20 && !seen) begin
      if (b8.Done === 1'b1) seen = 1'b1;
      if (b8.Busy !== (k < lat)) busy_ok = 1'b0;
      if (!seen) begin step(); k++; end
    end
    check_eq("x8_lat", seen ? k : 0, lat);
    check_eq("x8_busy", busy_ok, 1);
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d0;
    logic [7:0] corners[9];
    logic [31:0] ra, rb;
    logic [2:0] rf;
    corners = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    reset = 1'b1;
    b32.Start = 0; b32.Kill = 0; b32.Funct3 = 0; b32.SrcA = 0; b32.SrcB = 0;
    b8.Start = 0;  b8.Kill = 0;  b8.Funct3 = 0;  b8.SrcA = 0;  b8.SrcB = 0;
    step(); step();
    check_eq("rst_busy", b32.Busy, 0);
    check_eq("rst_done", b32.Done, 0);
    check_eq("rst_result", b32.Result, 0);
    reset = 1'b0;
    step();

    run32("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB); step();
    run32("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); step();
    run32("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); step();
    run32("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step();
    run32("div", 3'd4, -32'sd7, 32'd2, 32'hFFFF_FFFD); step();
    run32("rem", 3'd6, -32'sd7, 32'd2, 32'hFFFF_FFFF); step();
    run32("divu", 3'd5, 32'd7, 32'd2, 32'd3); step();
    run32("remu", 3'd7, 32'hFFFF_FFFF, 32'd16, 32'hF); step();
    run32("div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF); step();
    run32("remu0", 3'd7, 32'd5, 32'd0, 32'd5); step();
    run32("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); step();
    run32("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0); step();
    // consecutive special cases produce Done on two adjacent cycles
    run32("b2b_sp0", 3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run32("b2b_sp1", 3'd6, 32'd9, 32'd0, 32'd9); step();

    // back-to-back: second Start issued in the first Done cycle
    run32("b2b0", 3'd0, 32'd12, 32'd11, 32'd132);
    run32("b2b1", 3'd0, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB); step();

    // Kill at t+10 of a DIV
    d0 = done32;
    b32.Start = 1; b32.Funct3 = 3'd4; b32.SrcA = 32'd100; b32.SrcB = 32'd3;
    step();
    b32.Start = 0;
    repeat (9) step();
    check_eq("kill_busy_before", b32.Busy, 1);
    b32.Kill = 1;
    step();
    b32.Kill = 0;
    check_eq("kill_busy_after", b32.Busy, 0);
    check_eq("kill_done_after", b32.Done, 0);
    repeat (40) step();
    check_eq("kill_no_done", done32, d0);
    check_eq("kill_result_hold", b32.Result, 32'hFFFF_FFFB);

    // Start during RUN is ignored
    d0 = done32;
    q32.push_back(32'd15);
    b32.Start = 1; b32.Funct3 = 3'd0; b32.SrcA = 32'd3; b32.SrcB = 32'd5;
    step();
    b32.Start = 0;
    repeat (4) step();
    b32.Start = 1; b32.Funct3 = 3'd5; b32.SrcA = 32'd9; b32.SrcB = 32'd0;
    step();
    b32.Start = 0;
    wait_done32(6, k);
    check_eq("run_start_lat", k, 33);
    repeat (40) step();
    check_eq("run_start_one_done", done32, d0 + 1);

    // Kill and Start together
    d0 = done32;
    b32.Start = 1; b32.Kill = 1; b32.Funct3 = 3'd0; b32.SrcA = 32'd3; b32.SrcB = 32'd3;
    step();
    b32.Start = 0; b32.Kill = 0;
    check_eq("killstart_busy", b32.Busy, 0);
    repeat (40) step();
    check_eq("killstart_no_done", done32, d0);

    // reset mid-RUN, with Start held during the reset cycle
    d0 = done32;
    b32.Start = 1; b32.Funct3 = 3'd0; b32.SrcA = 32'd3; b32.SrcB = 32'd3;
    step();
    b32.Start = 0;
    repeat (4) step();
    reset = 1; b32.Start = 1;
    step();
    reset = 0; b32.Start = 0;
    check_eq("rstrun_busy", b32.Busy, 0);
    check_eq("rstrun_done", b32.Done, 0);
    check_eq("rstrun_result", b32.Result, 0);
    step();
    check_eq("rst_start_ignored", b32.Busy, 0);
    repeat (40) step();
    check_eq("rstrun_no_done", done32, d0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = (i % 6 == 5) ? 32'd0 : $urandom;
      rf = 3'($urandom_range(0, 7));
      run32("rand32", rf, ra, rb, model(32, rf, ra, rb));
      step();
    end

    for (int f = 0; f < 8; f++)
      for (int i = 0; i < 9; i++)
        for (int j = 0; j < 9; j++)
          run8(3'(f), corners[i], corners[j]);
    for (int i = 0; i < 200; i++)
      run8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));

    repeat (3) step();
    check_eq("q32_drained", q32.size(), 0);
    check_eq("q8_drained", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, sequential RV M-extension execute unit: the next generation of the ALU decode/execute path, covering MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands. Sits beside the single-cycle ALU in the execute stage. Accepts one operation on a Start pulse, iterates one bit per cycle, and returns a registered Result with a one-cycle Done pulse. A Kill input lets the hazard unit squash an in-flight operation on a flush.

## Interface

- XLEN, 32, operand/result width (≥ 4)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Start  in  1  request; sampled only in IDLE or DONE
- Funct3  in  3  RV M op select, sampled with Start
- SrcA  in  XLEN  rs1 operand (multiplicand / dividend), sampled with Start
- SrcB  in  XLEN  rs2 operand (multiplier / divisor), sampled with Start
- Kill  in  1  squash in-flight op
- Busy  out  1  high while iterating (RUN)
- Done  out  1  one-cycle pulse; Result valid
- Result  out  XLEN  registered result, held until next completion

## Operation

- Funct3 map: 000 MUL (low XLEN), 001 MULH (s×s high), 010 MULHSU (SrcA signed × SrcB unsigned, high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States: IDLE, RUN, DONE.
  - IDLE: Start → RUN; or → DONE directly for a special-case divide.
  - RUN: counter runs XLEN cycles; on last → DONE, Result loaded.
  - DONE: Done=1 for exactly one cycle; Start accepted here (back-to-back) with the same transitions as IDLE, else → IDLE.
- Start in RUN is ignored; no queueing.
- Sign handling: on Start, capture magnitudes of signed operands and the result sign. Core is unsigned shift-add (2·XLEN product) or restoring divide (XLEN quotient, XLEN remainder).
- Final correction: negate the product if operand signs differ. Negate the quotient if dividend and divisor signs differ. The remainder takes the dividend's sign.
- Special cases, detected at Start, bypassing RUN (→ DONE next cycle):
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → SrcA.
  - Signed overflow (DIV/REM, SrcA = 2^(XLEN-1), SrcB = all ones): DIV → 2^(XLEN-1); REM → 0.
- Kill: any state → IDLE next edge. Done is not asserted and Result is unchanged. Kill and Start in the same cycle: Kill wins and Start is dropped.
- reset: state IDLE; Busy=0, Done=0, Result=0, counter=0.

## Timing

- Start high in cycle t (IDLE/DONE), normal op: Busy=1 in cycles t+1..t+XLEN; Done=1 and new Result in cycle t+XLEN+1; Busy=0 that cycle.
- Special-case divide: Busy never asserts; Done and Result in cycle t+1.
- Back-to-back: Start in the DONE cycle t+XLEN+1 → next Done at t+2·XLEN+2. Throughput is one op per XLEN+1 cycles.
- Result changes only on the edge that enters DONE. It holds across IDLE, RUN and Kill.
- Kill in cycle k of RUN: Busy=0 from k+1; no Done for that op.
- reset asserted mid-RUN: outputs take reset values from the next cycle. Start in the reset cycle is ignored.
- Done never high in two consecutive cycles except on back-to-back special-case divides.

## Test plan

- MUL SrcA=7, SrcB=0xFFFFFFFD (XLEN=32), Start at t → Busy t+1..t+32, Done only at t+33, Result=0xFFFFFFEB.
- High multiplies → Done at t+33 with:
  - MULH 0x80000000×0x80000000 → 0x40000000
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF
- Divides:
  - DIV −7/2 → 0xFFFFFFFD
  - REM −7/2 → 0xFFFFFFFF
  - DIVU 7/2 → 3
  - REMU 0xFFFFFFFF/16 → 0xF
- Special cases → Done at t+1, Busy never high:
  - DIV 5/0 → 0xFFFFFFFF
  - REMU 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
  - REM same operands → 0
- Control: Kill at t+10 of a DIV → Busy=0 at t+11, no Done, Result holds prior value. Start during RUN is ignored. Kill+Start same cycle → stays IDLE. reset mid-RUN → all outputs 0 next cycle.
- Throughput and width: back-to-back MUL with Start in the DONE cycle → second Done exactly 33 cycles after the first. Separately, XLEN=8 exhaustive all-ops sweep matches a reference model, Done at t+9.
